// File: rtl/branch_ctrl_if.sv
// Bus between the fetch stage and the IF/ID branch controller.
// Optional statistics signals exist only when BRANCH_STATS_EN is defined.
interface branch_ctrl_if;
    logic [15:0] imem_rdata;
    logic [15:0] pc_next_in;
    logic        flag_z;
    logic [15:0] rs_data;
    logic [15:0] id_instr;
    logic [15:0] id_pc_next;
    logic        id_valid;
    logic [1:0]  pc_sel;
    logic        jr_sel;
    logic [15:0] jmp8;
    logic [15:0] jmp11;
    logic [15:0] jmpr;
`ifdef BRANCH_STATS_EN
    logic [15:0] br_taken_cnt;
    logic [15:0] br_total_cnt;

    modport master (
        output imem_rdata, pc_next_in, flag_z, rs_data,
        input  id_instr, id_pc_next, id_valid, pc_sel, jr_sel,
               jmp8, jmp11, jmpr, br_taken_cnt, br_total_cnt
    );
    modport slave (
        input  imem_rdata, pc_next_in, flag_z, rs_data,
        output id_instr, id_pc_next, id_valid, pc_sel, jr_sel,
               jmp8, jmp11, jmpr, br_taken_cnt, br_total_cnt
    );
`else
    modport master (
        output imem_rdata, pc_next_in, flag_z, rs_data,
        input  id_instr, id_pc_next, id_valid, pc_sel, jr_sel,
               jmp8, jmp11, jmpr
    );
    modport slave (
        input  imem_rdata, pc_next_in, flag_z, rs_data,
        output id_instr, id_pc_next, id_valid, pc_sel, jr_sel,
               jmp8, jmp11, jmpr
    );
`endif
endinterface

// File: rtl/branch_ctrl.sv
// IF/ID pipeline register and branch resolver for the 16-bit pipeline.
// Decodes BEZ/BNZ/JMP/JR in ID, drives the fetch redirect controls and
// squashes wrong-path instructions with a small flush FSM.
// Optional feature: define BRANCH_STATS_EN to add saturating branch counters.
module branch_ctrl #(
    parameter int unsigned FLUSH_SLOTS = 1,          // legal 1..3
    parameter logic [15:0] NOP_INSTR   = 16'h0000
) (
    input  logic          clk,
    input  logic          rst_n,
    branch_ctrl_if.slave  bus
);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam logic [4:0] OP_BEZ = 5'b10000;
    localparam logic [4:0] OP_BNZ = 5'b10001;
    localparam logic [4:0] OP_JMP = 5'b10100;
    localparam logic [4:0] OP_JR  = 5'b10101;

    localparam logic [1:0] FLUSH_CNT_INIT = 2'(FLUSH_SLOTS - 1);

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  cnt;
    logic [1:0]  cnt_nxt;
    logic        load;

    logic [15:0] id_instr_r;
    logic [15:0] id_pc_next_r;
    logic        id_valid_r;

    logic [4:0]  opcode;
    logic        taken;
    logic [1:0]  pc_sel_d;
    logic        jr_sel_d;

    assign opcode = id_instr_r[15:11];

    // Resolve the control-flow op sitting in ID (only real instructions decode)
    always_comb begin
        taken    = 1'b0;
        pc_sel_d = 2'd0;
        jr_sel_d = 1'b0;
        if (id_valid_r) begin
            case (opcode)
                OP_BEZ: if (bus.flag_z) begin
                    taken    = 1'b1;
                    pc_sel_d = 2'd1;
                end
                OP_BNZ: if (!bus.flag_z) begin
                    taken    = 1'b1;
                    pc_sel_d = 2'd1;
                end
                OP_JMP: begin
                    taken    = 1'b1;
                    pc_sel_d = 2'd2;
                end
                OP_JR: begin
                    taken    = 1'b1;
                    jr_sel_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Flush FSM next state; load marks a fetch that may enter ID as valid
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load      = 1'b0;
        case (state)
            RUN: begin
                if (taken) begin
                    if (FLUSH_SLOTS > 1) begin
                        state_nxt = FLUSH;
                        cnt_nxt   = FLUSH_CNT_INIT;
                    end
                end else begin
                    load = 1'b1;
                end
            end
            FLUSH: begin
                if (cnt <= 2'd1) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - 2'd1;
                end
            end
            default: begin
                state_nxt = RUN;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Flush FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // IF/ID register; squashed slots carry the NOP but still track pc_next
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_instr_r   <= NOP_INSTR;
            id_pc_next_r <= '0;
            id_valid_r   <= 1'b0;
        end else begin
            id_instr_r   <= load ? bus.imem_rdata : NOP_INSTR;
            id_pc_next_r <= bus.pc_next_in;
            id_valid_r   <= load;
        end
    end

    assign bus.id_instr   = id_instr_r;
    assign bus.id_pc_next = id_pc_next_r;
    assign bus.id_valid   = id_valid_r;
    assign bus.pc_sel     = rst_n ? pc_sel_d : 2'd0;
    assign bus.jr_sel     = rst_n ? jr_sel_d : 1'b0;
    assign bus.jmp8       = {{8{id_instr_r[7]}}, id_instr_r[7:0]};
    assign bus.jmp11      = {{5{id_instr_r[10]}}, id_instr_r[10:0]};
    assign bus.jmpr       = bus.rs_data;

`ifdef BRANCH_STATS_EN
    logic        is_branch;
    logic [15:0] taken_cnt;
    logic [15:0] total_cnt;

    assign is_branch = id_valid_r &&
                       (opcode == OP_BEZ || opcode == OP_BNZ ||
                        opcode == OP_JMP || opcode == OP_JR);

    // Saturating counters of decoded and taken control-flow ops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken_cnt <= '0;
            total_cnt <= '0;
        end else begin
            if (is_branch && total_cnt != '1) begin
                total_cnt <= total_cnt + 16'd1;
            end
            if (taken && taken_cnt != '1) begin
                taken_cnt <= taken_cnt + 16'd1;
            end
        end
    end

    assign bus.br_taken_cnt = taken_cnt;
    assign bus.br_total_cnt = total_cnt;
`endif

endmodule
